// File: rtl/ifq_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, instruction-queue
// write port and the redirect request from dispatch/branch logic.
//   master : fetch unit (drives imem_rd/imem_addr, iq_push/iq_data/iq_flush)
//   slave  : environment (memory, queue, branch logic)
interface ifq_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                              imem_rd;
    logic [ADDR_WIDTH-1:0]             imem_addr;
    logic [INSTR_WIDTH-1:0]            imem_rdata;
    logic                              iq_push;
    logic [ADDR_WIDTH+INSTR_WIDTH-1:0] iq_data;
    logic                              iq_full;
    logic                              iq_flush;
    logic                              redirect_valid;
    logic [ADDR_WIDTH-1:0]             redirect_pc;

    modport master (
        output imem_rd, imem_addr, iq_push, iq_data, iq_flush,
        input  imem_rdata, iq_full, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_rd, imem_addr, iq_push, iq_data, iq_flush,
        output imem_rdata, iq_full, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifq_fetch_unit.sv
// Writer side of the dispatch instruction queue.
// Fetches sequentially from a synchronous-read instruction memory, pushes
// {pc, instr} into the queue, restarts on redirect, and parks the in-flight
// word in a one-entry hold register when the queue fills.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ifq_fetch_unit_if.master (imem read port, queue write port, redirect)
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// RUN   | issuing one read per cycle while the queue is not full
// HOLD  | queue filled with a word in flight; word parked until space frees
module ifq_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(32'h0040_0000)
) (
    input  logic              clk,
    input  logic              rst,
    ifq_fetch_unit_if.master  bus
);
    localparam int DATA_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   inflight_pc;
    logic                    inflight;
    logic                    hold_valid;
    logic [DATA_WIDTH-1:0]   hold_data;

    logic                    redirect;
    logic                    issue;
    logic                    push_resp;
    logic                    push_hold;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   resp_word;

    // Redirect overrides everything in the same cycle; gated by rst so the
    // flush output also reads 0 while reset is held.
    always_comb begin
        redirect  = bus.redirect_valid && !rst;
        resp_word = {inflight_pc, bus.imem_rdata};
        issue     = (state == RUN) && !bus.iq_full && !redirect;
        push_resp = (state == RUN) && inflight && !bus.iq_full && !redirect;
        capture   = (state == RUN) && inflight && bus.iq_full && !redirect;
        push_hold = (state == HOLD) && hold_valid && !bus.iq_full && !redirect;
    end

    assign bus.imem_rd   = issue;
    assign bus.imem_addr = pc;
    assign bus.iq_push   = push_resp || push_hold;
    assign bus.iq_data   = push_hold ? hold_data : (push_resp ? resp_word : '0);
    assign bus.iq_flush  = redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
        end else if (redirect) begin
            // Kills any in-flight response and any parked word.
            state      <= RUN;
            pc         <= bus.redirect_pc & ~ADDR_WIDTH'(3);
            inflight   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (capture) begin
                        hold_data  <= resp_word;
                        hold_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.iq_full) begin
                        hold_valid <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + ADDR_WIDTH'(4);
            end
        end
    end
endmodule

// File: tb/tb_ifq_fetch_unit.sv
module tb_ifq_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ifq_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    ifq_fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Instruction memory content is a fixed function of the address.
    function automatic logic [31:0] mem_f(logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_rdata <= mem_f(bus.imem_addr);
    end

    typedef struct packed {
        logic        full;
        logic        redir;
        logic [31:0] rpc;
        logic        rd;
        logic [31:0] addr;
        logic        push;
        logic [31:0] ppc;
        logic        flush;
    } step_t;

    function automatic step_t s(logic full, logic redir, logic [31:0] rpc, logic rd,
                                logic [31:0] addr, logic push, logic [31:0] ppc, logic flush);
        step_t t;
        t.full = full; t.redir = redir; t.rpc = rpc; t.rd = rd;
        t.addr = addr; t.push = push; t.ppc = ppc; t.flush = flush;
        return t;
    endfunction

    function automatic logic [98:0] expv(step_t t);
        return {t.rd, t.addr, t.push, t.push ? {t.ppc, mem_f(t.ppc)} : 64'h0, t.flush};
    endfunction

    function automatic logic [98:0] obs();
        return {bus.imem_rd, bus.imem_addr, bus.iq_push, bus.iq_data, bus.iq_flush};
    endfunction

    task automatic drive(step_t t);
        bus.iq_full        = t.full;
        bus.redirect_valid = t.redir;
        bus.redirect_pc    = t.rpc;
    endtask

    // Leaves the bench at posedge+1 of the BOOT cycle.
    task automatic apply_reset();
        rst = 1'b1;
        bus.iq_full = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        step_t r;
        r = s(0, 0, 0, 0, RESET_PC, 0, 0, 0);
        rst = 1'b1;
        bus.iq_full = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h1234_5670;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== expv(r))
            begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs(), expv(r)); end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_sequential();
        step_t t[$];
        apply_reset();
        t.push_back(s(0, 0, 0, 0, RESET_PC, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            t.push_back(s(0, 0, 0, 1, RESET_PC + 32'(4 * i), i > 0, RESET_PC + 32'(4 * (i - 1)), 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            checks++;
            if (obs() !== expv(t[i]))
                begin failures++; $display("FAIL sequential[%0d] got=%h exp=%h", i, obs(), expv(t[i])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_hold();
        step_t t[$];
        apply_reset();
        t.push_back(s(0, 0, 0, 0, 32'h0040_0000, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0000, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0004, 1, 32'h0040_0000, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0008, 1, 32'h0040_0004, 0));
        t.push_back(s(1, 0, 0, 0, 32'h0040_000C, 0, 0, 0));
        t.push_back(s(1, 0, 0, 0, 32'h0040_000C, 0, 0, 0));
        t.push_back(s(1, 0, 0, 0, 32'h0040_000C, 0, 0, 0));
        t.push_back(s(0, 0, 0, 0, 32'h0040_000C, 1, 32'h0040_0008, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_000C, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_000C, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            checks++;
            if (obs() !== expv(t[i]))
                begin failures++; $display("FAIL full_hold[%0d] got=%h exp=%h", i, obs(), expv(t[i])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        step_t t[$];
        apply_reset();
        t.push_back(s(0, 0, 0, 0, 32'h0040_0000, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0000, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0004, 1, 32'h0040_0000, 0));
        t.push_back(s(0, 1, 32'h0040_0103, 0, 32'h0040_0008, 0, 0, 1));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0100, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0104, 1, 32'h0040_0100, 0));
        t.push_back(s(0, 1, 32'h0060_0000, 0, 32'h0040_0108, 0, 0, 1));
        t.push_back(s(0, 1, 32'h0070_0006, 0, 32'h0060_0000, 0, 0, 1));
        t.push_back(s(0, 0, 0, 1, 32'h0070_0004, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0070_0008, 1, 32'h0070_0004, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            checks++;
            if (obs() !== expv(t[i]))
                begin failures++; $display("FAIL redirect[%0d] got=%h exp=%h", i, obs(), expv(t[i])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_boot();
        step_t t[$];
        apply_reset();
        t.push_back(s(0, 1, 32'h0080_0001, 0, 32'h0040_0000, 0, 0, 1));
        t.push_back(s(0, 0, 0, 1, 32'h0080_0000, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0080_0004, 1, 32'h0080_0000, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            checks++;
            if (obs() !== expv(t[i]))
                begin failures++; $display("FAIL redirect_boot[%0d] got=%h exp=%h", i, obs(), expv(t[i])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_hold();
        step_t t[$];
        apply_reset();
        t.push_back(s(0, 0, 0, 0, 32'h0040_0000, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0000, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0004, 1, 32'h0040_0000, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0040_0008, 1, 32'h0040_0004, 0));
        t.push_back(s(1, 0, 0, 0, 32'h0040_000C, 0, 0, 0));
        t.push_back(s(1, 1, 32'h0050_0009, 0, 32'h0040_000C, 0, 0, 1));
        t.push_back(s(1, 0, 0, 0, 32'h0050_0008, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0050_0008, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0050_000C, 1, 32'h0050_0008, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            checks++;
            if (obs() !== expv(t[i]))
                begin failures++; $display("FAIL redirect_hold[%0d] got=%h exp=%h", i, obs(), expv(t[i])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_reset();
        step_t t[$];
        step_t r;
        r = s(0, 0, 0, 0, RESET_PC, 0, 0, 0);
        apply_reset();
        t.push_back(s(0, 1, 32'hFFFF_FFF8, 0, 32'h0040_0000, 0, 0, 1));
        t.push_back(s(0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0));
        t.push_back(s(0, 0, 0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0));
        t.push_back(s(1, 0, 0, 0, 32'h0000_0004, 0, 0, 0));
        t.push_back(s(1, 0, 0, 0, 32'h0000_0004, 0, 0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            checks++;
            if (obs() !== expv(t[i]))
                begin failures++; $display("FAIL wrap[%0d] got=%h exp=%h", i, obs(), expv(t[i])); end
            @(posedge clk); #1;
        end
        // Mid-cycle reset while a word is parked: outputs must drop at once.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== expv(r))
            begin failures++; $display("FAIL reset_mid_stall got=%h exp=%h", obs(), expv(r)); end
        bus.iq_full = 1'b0;
        #1;
        checks++;
        if (obs() !== expv(r))
            begin failures++; $display("FAIL reset_unfull got=%h exp=%h", obs(), expv(r)); end
        @(posedge clk); #1 rst = 1'b0;
        t.delete();
        t.push_back(s(0, 0, 0, 0, RESET_PC, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, RESET_PC, 0, 0, 0));
        t.push_back(s(0, 0, 0, 1, RESET_PC + 32'd4, 1, RESET_PC, 0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            checks++;
            if (obs() !== expv(t[i]))
                begin failures++; $display("FAIL after_reset[%0d] got=%h exp=%h", i, obs(), expv(t[i])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [63:0] sb[$];
        logic [63:0] e;
        logic [31:0] exp_pc;
        logic        redir;
        logic [31:0] rpc;
        int          pushes;
        pushes = 0;
        exp_pc = RESET_PC;
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            redir = ($urandom_range(0, 99) < 3);
            rpc   = $urandom;
            bus.iq_full        = ($urandom_range(0, 99) < 35);
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            @(negedge clk);
            checks++;
            if (bus.iq_flush !== redir)
                begin failures++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, bus.iq_flush, redir); end
            if (bus.iq_push) begin
                pushes++;
                checks++;
                if (bus.iq_full || redir)
                    begin failures++; $display("FAIL rnd_push_blocked c=%0d full=%b redir=%b", c, bus.iq_full, redir); end
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL rnd_push_unexpected c=%0d got=%h", c, bus.iq_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.iq_data !== e)
                        begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.iq_data, e); end
                end
            end
            if (bus.imem_rd) begin
                checks++;
                if (bus.iq_full || redir)
                    begin failures++; $display("FAIL rnd_rd_blocked c=%0d full=%b redir=%b", c, bus.iq_full, redir); end
                checks++;
                if (bus.imem_addr !== exp_pc)
                    begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bus.imem_addr, exp_pc); end
                sb.push_back({exp_pc, mem_f(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) begin
                sb.delete();
                exp_pc = rpc & ~32'd3;
            end
            checks++;
            if (sb.size() > 1)
                begin failures++; $display("FAIL rnd_backlog c=%0d got=%0d exp<=1", c, sb.size()); end
            @(posedge clk); #1;
        end
        checks++;
        if (pushes < 1000)
            begin failures++; $display("FAIL rnd_throughput got=%0d exp>=1000", pushes); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_hold();
        test_redirect();
        test_redirect_boot();
        test_redirect_hold();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
